// File: rtl/mips_divider_pkg.sv
// Shared definitions for the div/divu iterative divider and the controller
// that stalls on it.
package mips_divider_pkg;

    localparam int DIV_N       = 32;
    localparam int DIV_LATENCY = DIV_N + 1;

    localparam logic [5:0] DIV  = 6'b011010;
    localparam logic [5:0] DIVU = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } div_state_t;

endpackage

// File: rtl/mips_divider_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// applying the result signs.
module div_sign_fix #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_val,
    input  logic         i_neg,
    output logic [N-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + {{(N-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/mips_divider.sv
// Restoring divider for div/divu: quotient to LO (o_q), remainder to HI (o_r),
// fixed N+1 edge latency, one edge for divide-by-zero.
module mips_divider
    import mips_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic         i_is_signed,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_div_by_zero,
    output logic [N-1:0] o_q,
    output logic [N-1:0] o_r,
    output div_state_t   o_state
);

    localparam int CW = $clog2(N);

    // Handshake: i_start is sampled only while o_busy=0; o_done pulses one
    // cycle with o_q/o_r valid, and the divider is already idle in that cycle.

    div_state_t    r_state;
    logic [N:0]    r_rem;
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_divisor;
    logic [CW-1:0] r_cnt;
    logic          r_sign_q;
    logic          r_sign_r;
    logic          r_busy;
    logic          r_done;
    logic          r_dbz;
    logic [N-1:0]  r_q;
    logic [N-1:0]  r_r;

    logic          w_idle;
    logic [N-1:0]  w_fix_in;
    logic          w_fix_neg;
    logic [N-1:0]  w_fix_out;
    logic [N-1:0]  w_abs_b;
    logic [N-1:0]  w_rem_fix;
    logic [N+1:0]  w_shift;
    logic [N+1:0]  w_trial;

    assign w_idle = (r_state == IDLE);

    // One negator serves |a| while idle and the quotient sign in FIX.
    assign w_fix_in  = w_idle ? i_a : r_quo;
    assign w_fix_neg = w_idle ? (i_is_signed & i_a[N-1]) : r_sign_q;

    div_sign_fix #(.N(N)) u_fix_aq (
        .i_val (w_fix_in),
        .i_neg (w_fix_neg),
        .o_val (w_fix_out)
    );

    div_sign_fix #(.N(N)) u_fix_b (
        .i_val (i_b),
        .i_neg (i_is_signed & i_b[N-1]),
        .o_val (w_abs_b)
    );

    div_sign_fix #(.N(N)) u_fix_r (
        .i_val (r_rem[N-1:0]),
        .i_neg (r_sign_r),
        .o_val (w_rem_fix)
    );

    assign w_shift = {r_rem, r_quo[N-1]};
    assign w_trial = w_shift - {2'b00, r_divisor};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_q       <= '0;
            r_r       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_busy   <= 1'b1;
                        r_dbz    <= 1'b0;
                        r_rem    <= '0;
                        r_cnt    <= CW'(N - 1);
                        r_sign_q <= i_is_signed & (i_a[N-1] ^ i_b[N-1]);
                        r_sign_r <= i_is_signed & i_a[N-1];
                        if (i_b == '0) begin
                            // Raw dividend parked in r_quo becomes HI.
                            r_quo   <= i_a;
                            r_state <= ZERO;
                        end else begin
                            r_quo     <= w_fix_out;
                            r_divisor <= w_abs_b;
                            r_state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!w_trial[N+1]) begin
                        r_rem <= w_trial[N:0];
                        r_quo <= {r_quo[N-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[N:0];
                        r_quo <= {r_quo[N-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_state <= FIX;
                end
                FIX: begin
                    r_q     <= w_fix_out;
                    r_r     <= w_rem_fix;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                ZERO: begin
                    r_q     <= '1;
                    r_r     <= r_quo;
                    r_dbz   <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_div_by_zero = r_dbz;
    assign o_q           = r_q;
    assign o_r           = r_r;
    assign o_state       = r_state;

endmodule
